// File: rtl/sram1r1w_arbiter_pkg.sv
// Shared types and helpers for the 1R1W SRAM sequencer/arbiter.
package sram1r1w_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_EMPTY = 2'd0,
        RSP_LIVE  = 2'd1,
        RSP_HELD  = 2'd2
    } rsp_state_e;

    typedef enum logic {
        TOP_INIT = 1'b0,
        TOP_RUN  = 1'b1
    } top_state_e;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram1r1w_arbiter_rr.sv
// Round-robin arbiter: priority starts one past the last grant, pointer moves only when advance is set.
module rr_arbiter
    import sram1r1w_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = id_width(N);

    logic [PW-1:0] last_q;
    logic [PW-1:0] win_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        win_d = last_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = PW'((32'(last_q) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win_d      = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PW'(N - 1);
        end else if (advance && found) begin
            last_q <= win_d;
        end
    end

endmodule

// File: rtl/sram1r1w_arbiter.sv
// Initialises a 1R1W SRAM after reset, then round-robin shares its read and write ports;
// read responses leave on one valid/ready channel with a hold register for backpressure.
module sram1r1w_arbiter
    import sram1r1w_arbiter_pkg::*;
#(
    parameter int unsigned    NUM_RD   = 2,
    parameter int unsigned    NUM_WR   = 2,
    parameter int unsigned    AW       = 3,
    parameter int unsigned    DW       = 17,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_RD-1:0]             rd_req_valid,
    input  logic [NUM_RD*AW-1:0]          rd_req_addr,
    output logic [NUM_RD-1:0]             rd_req_ready,
    input  logic [NUM_WR-1:0]             wr_req_valid,
    input  logic [NUM_WR*AW-1:0]          wr_req_addr,
    input  logic [NUM_WR*DW-1:0]          wr_req_data,
    output logic [NUM_WR-1:0]             wr_req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(NUM_RD)-1:0]   rsp_id,
    output logic [DW-1:0]                 rsp_data,
    output logic                          init_done,
    output logic                          mem_w_en,
    output logic [AW-1:0]                 mem_w_addr,
    output logic [DW-1:0]                 mem_w_data,
    output logic                          mem_r_en,
    output logic [AW-1:0]                 mem_r_addr,
    input  logic [DW-1:0]                 mem_r_data
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned IDW   = id_width(NUM_RD);

    top_state_e      top_q;
    rsp_state_e      rsp_q;
    logic [AW-1:0]   cnt_q;
    logic [IDW-1:0]  id_q;
    logic [DW-1:0]   hold_q;

    logic [NUM_RD-1:0] rd_grant;
    logic [NUM_WR-1:0] wr_grant;
    logic [AW-1:0]     rd_addr;
    logic [IDW-1:0]    rd_idx;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              run;
    logic              init_wr;
    logic              slot_free;
    logic              rd_go;
    logic              wr_go;

    // Reset wins over whatever state is still registered in the reset cycle.
    assign run       = (top_q == TOP_RUN) && !reset;
    assign init_wr   = (top_q == TOP_INIT) && !reset;
    assign slot_free = (rsp_q == RSP_EMPTY) || rsp_ready;
    assign rd_go     = run && slot_free && (|rd_grant);
    assign wr_go     = run && (|wr_grant);

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk     (clock),
        .reset   (reset),
        .req     (rd_req_valid),
        .advance (rd_go),
        .grant   (rd_grant)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk     (clock),
        .reset   (reset),
        .req     (wr_req_valid),
        .advance (wr_go),
        .grant   (wr_grant)
    );

    // One-hot grant selects the winner's address, data and index.
    always_comb begin
        rd_addr = '0;
        rd_idx  = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd_grant[i]) begin
                rd_addr = rd_req_addr[i*AW +: AW];
                rd_idx  = IDW'(i);
            end
        end
        wr_addr = '0;
        wr_data = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_grant[i]) begin
                wr_addr = wr_req_addr[i*AW +: AW];
                wr_data = wr_req_data[i*DW +: DW];
            end
        end
    end

    assign rd_req_ready = rd_go ? rd_grant : '0;
    assign wr_req_ready = wr_go ? wr_grant : '0;

    assign mem_w_en   = init_wr || wr_go;
    assign mem_w_addr = init_wr ? cnt_q : wr_addr;
    assign mem_w_data = init_wr ? INIT_VAL : wr_data;
    assign mem_r_en   = rd_go;
    assign mem_r_addr = rd_addr;

    assign init_done = (top_q == TOP_RUN);
    assign rsp_valid = (rsp_q != RSP_EMPTY);
    assign rsp_id    = id_q;
    assign rsp_data  = (rsp_q == RSP_HELD) ? hold_q : mem_r_data;

    // Top and response FSMs; the macro output may change under later writes, so a stalled
    // live response is captured into hold_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            top_q  <= TOP_INIT;
            cnt_q  <= '0;
            rsp_q  <= RSP_EMPTY;
            id_q   <= '0;
            hold_q <= '0;
        end else begin
            if (top_q == TOP_INIT) begin
                cnt_q <= cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    top_q <= TOP_RUN;
                end
            end

            if (rd_go) begin
                id_q <= rd_idx;
            end

            case (rsp_q)
                RSP_EMPTY: begin
                    if (rd_go) begin
                        rsp_q <= RSP_LIVE;
                    end
                end
                RSP_LIVE: begin
                    if (rsp_ready) begin
                        rsp_q <= rd_go ? RSP_LIVE : RSP_EMPTY;
                    end else begin
                        hold_q <= mem_r_data;
                        rsp_q  <= RSP_HELD;
                    end
                end
                RSP_HELD: begin
                    if (rsp_ready) begin
                        rsp_q <= rd_go ? RSP_LIVE : RSP_EMPTY;
                    end
                end
                default: rsp_q <= RSP_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sram1r1w_arbiter.sv
// Directed bench for sram1r1w_arbiter with a write-first 1R1W SRAM model whose output follows later writes.
module tb_sram1r1w_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_req_valid;
    logic [5:0]  rd_req_addr;
    logic [1:0]  rd_req_ready;
    logic [1:0]  wr_req_valid;
    logic [5:0]  wr_req_addr;
    logic [33:0] wr_req_data;
    logic [1:0]  wr_req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [16:0] rsp_data;
    logic        init_done;
    logic        mem_w_en;
    logic [2:0]  mem_w_addr;
    logic [16:0] mem_w_data;
    logic        mem_r_en;
    logic [2:0]  mem_r_addr;
    logic [16:0] mem_r_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] mem [8];
    logic [2:0]  raddr_q = 3'd0;

    always #5 clk = ~clk;

    sram1r1w_arbiter dut (
        .clock        (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_ready (rd_req_ready),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_ready (wr_req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .mem_w_en     (mem_w_en),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_en     (mem_r_en),
        .mem_r_addr   (mem_r_addr),
        .mem_r_data   (mem_r_data)
    );

    // SRAM model: registered read address, array read combinationally, so writes show through.
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) raddr_q <= mem_r_addr;
    end
    assign mem_r_data = mem[raddr_q];

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 17'h1DEAD;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        rd_req_valid = '0; rd_req_addr = '0;
        wr_req_valid = '0; wr_req_addr = '0; wr_req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({rd_req_ready, wr_req_ready, rsp_valid, init_done, mem_r_en, mem_w_en} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {rd_req_ready, wr_req_ready, rsp_valid, init_done, mem_r_en, mem_w_en});
        end
        // Requests held during init must never be granted.
        reset = 1'b0; rd_req_valid = 2'b11; wr_req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 3'(k), 17'h0}) begin
                n_bad++;
                $display("FAIL init_walk[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=0",
                         k, mem_w_en, mem_w_addr, mem_w_data, k);
            end
            n_cmp++;
            if ({rd_req_ready, wr_req_ready, init_done, mem_r_en} !== 6'b0) begin
                n_bad++;
                $display("FAIL init_quiet[%0d]: got rdy=%b/%b done=%b ren=%b expected all 0",
                         k, rd_req_ready, wr_req_ready, init_done, mem_r_en);
            end
            @(negedge clk);
        end
        rd_req_valid = '0; wr_req_valid = '0;
        #1;
        n_cmp++;
        if ({init_done, mem_w_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL init_done_cycle8: got done=%b wen=%b expected done=1 wen=0", init_done, mem_w_en);
        end
    endtask

    task automatic test_read_basic();
        @(negedge clk);
        rd_req_valid = 2'b10; rd_req_addr = {3'd5, 3'd0}; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rd_req_ready, mem_r_en, mem_r_addr} !== {2'b10, 1'b1, 3'd5}) begin
            n_bad++;
            $display("FAIL read_grant: got rdy=%b ren=%b addr=%0d expected rdy=10 ren=1 addr=5",
                     rd_req_ready, mem_r_en, mem_r_addr);
        end
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 17'h0}) begin
            n_bad++;
            $display("FAIL read_rsp: got v=%b id=%0d data=%h expected v=1 id=1 data=0",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL read_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_rr_read();
        logic [1:0] exp_g;
        logic [2:0] exp_a;
        rd_req_addr = {3'd3, 3'd1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_req_valid = 2'b11;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (k % 2 == 0) ? 3'd1 : 3'd3;
            #1;
            n_cmp++;
            if ({rd_req_ready, mem_r_addr} !== {exp_g, exp_a}) begin
                n_bad++;
                $display("FAIL rr_read[%0d]: got rdy=%b addr=%0d expected rdy=%b addr=%0d",
                         k, rd_req_ready, mem_r_addr, exp_g, exp_a);
            end
            if (k > 0) begin
                n_cmp++;
                if ({rsp_valid, rsp_id} !== {1'b1, 1'((k - 1) % 2)}) begin
                    n_bad++;
                    $display("FAIL rr_read_rsp[%0d]: got v=%b id=%0d expected v=1 id=%0d",
                             k, rsp_valid, rsp_id, (k - 1) % 2);
                end
            end
        end
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id} !== 2'b11) begin
            n_bad++;
            $display("FAIL rr_read_last: got v=%b id=%0d expected v=1 id=1", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_rr_write();
        logic [1:0]  exp_g;
        logic [16:0] exp_d;
        wr_req_addr = {3'd7, 3'd6};
        wr_req_data = {17'h00BBB, 17'h00AAA};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wr_req_valid = 2'b11;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 17'h00AAA : 17'h00BBB;
            #1;
            n_cmp++;
            if ({wr_req_ready, mem_w_en, mem_w_data} !== {exp_g, 1'b1, exp_d}) begin
                n_bad++;
                $display("FAIL rr_write[%0d]: got rdy=%b wen=%b data=%h expected rdy=%b wen=1 data=%h",
                         k, wr_req_ready, mem_w_en, mem_w_data, exp_g, exp_d);
            end
        end
        @(negedge clk);
        wr_req_valid = '0;
        #1;
        n_cmp++;
        if ({mem[6], mem[7]} !== {17'h00AAA, 17'h00BBB}) begin
            n_bad++;
            $display("FAIL rr_write_mem: got %h %h expected 00aaa 00bbb", mem[6], mem[7]);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        wr_req_valid = 2'b01; wr_req_addr = {3'd0, 3'd2}; wr_req_data = {17'h0, 17'h1ABCD};
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (wr_req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_write: got wr_rdy=%b expected 01", wr_req_ready);
        end
        @(negedge clk);
        wr_req_valid = '0; rd_req_valid = 2'b01; rd_req_addr = {3'd0, 3'd2};
        #1;
        n_cmp++;
        if (rd_req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_read_grant: got rd_rdy=%b expected 01", rd_req_ready);
        end
        // Stall cycle 1: overwrite addr 2 while the response is live.
        @(negedge clk);
        wr_req_valid = 2'b01; wr_req_data = {17'h0, 17'h00001};
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rd_req_ready, wr_req_ready} !== {1'b1, 1'b0, 17'h1ABCD, 2'b00, 2'b01}) begin
            n_bad++;
            $display("FAIL bp_stall0: got v=%b id=%0d data=%h rd=%b wr=%b expected v=1 id=0 data=1abcd rd=00 wr=01",
                     rsp_valid, rsp_id, rsp_data, rd_req_ready, wr_req_ready);
        end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            wr_req_valid = '0;
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_data, rd_req_ready} !== {1'b1, 1'b0, 17'h1ABCD, 2'b00}) begin
                n_bad++;
                $display("FAIL bp_stall%0d: got v=%b id=%0d data=%h rd=%b expected v=1 id=0 data=1abcd rd=00",
                         k, rsp_valid, rsp_id, rsp_data, rd_req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rd_req_ready} !== {1'b1, 17'h1ABCD, 2'b01}) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b data=%h rd=%b expected v=1 data=1abcd rd=01",
                     rsp_valid, rsp_data, rd_req_ready);
        end
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 17'h00001}) begin
            n_bad++;
            $display("FAIL bp_reread: got v=%b data=%h expected v=1 data=00001", rsp_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_req_valid = 2'b01; wr_req_addr = {3'd0, 3'd4}; wr_req_data = {17'h0, 17'h12345};
        rd_req_valid = 2'b10; rd_req_addr = {3'd4, 3'd0};
        #1;
        n_cmp++;
        if ({wr_req_ready, rd_req_ready} !== 4'b0110) begin
            n_bad++;
            $display("FAIL coll_grant: got wr=%b rd=%b expected wr=01 rd=10", wr_req_ready, rd_req_ready);
        end
        @(negedge clk);
        wr_req_valid = '0; rd_req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 17'h12345}) begin
            n_bad++;
            $display("FAIL coll_rsp: got v=%b id=%0d data=%h expected v=1 id=1 data=12345",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rd_req_valid = 2'b01; rd_req_addr = {3'd0, 3'd4}; rsp_ready = 1'b0;
        #1;
        @(negedge clk);
        rd_req_valid = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 17'h12345}) begin
            n_bad++;
            $display("FAIL mid_held: got v=%b data=%h expected v=1 data=12345", rsp_valid, rsp_data);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, init_done, mem_w_en, mem_r_en} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%b done=%b wen=%b ren=%b expected all 0",
                     rsp_valid, init_done, mem_w_en, mem_r_en);
        end
        reset = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if ({mem_w_en, mem_w_addr, mem_w_data, init_done} !== {1'b1, 3'(k), 17'h0, 1'b0}) begin
                n_bad++;
                $display("FAIL reinit[%0d]: got en=%b addr=%0d data=%h done=%b expected en=1 addr=%0d data=0 done=0",
                         k, mem_w_en, mem_w_addr, mem_w_data, init_done, k);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL reinit_done: got %b expected 1", init_done);
        end
        @(negedge clk);
        rd_req_valid = 2'b01; rd_req_addr = {3'd0, 3'd4};
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 17'h0}) begin
            n_bad++;
            $display("FAIL reinit_read: got v=%b id=%0d data=%h expected v=1 id=0 data=0",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_rr_read();
        test_rr_write();
        test_backpressure();
        test_collision();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
